// File: rtl/instr_fetch_unit.sv
// Fetch stage: keeps the PC, issues one instruction-memory request at a time and hands
// fetched words to decode over valid/ready. Redirects abandon in-flight work.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
);

    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] redir_pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next datapath values; addr_d is only reloaded when a new live request starts
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        redir_pc  = redirect_pc & ~XLEN'(3);
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                addr_d  = pc_q;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    valid_d = 1'b0;
                    if (imem_ack) begin
                        state_d = S_FETCH;
                        addr_d  = redir_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + XLEN'(PC_STEP);
                    valid_d   = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    addr_d  = redir_pc;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (inst_ready) begin
                    addr_d  = pc_q;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Abandoned request keeps its address until memory answers it
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (imem_ack) begin
                    addr_d  = redirect_valid ? redir_pc : pc_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request is decoded purely from state, never from imem_ack
    always_comb begin
        imem_req = 1'b0;
        case (state_q)
            S_FETCH, S_DRAIN: imem_req = 1'b1;
            default:          imem_req = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            inst_q    <= NOP;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_addr  = addr_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign opcode     = inst_q[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .PC_STEP(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .opcode(opcode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding request (wanted or abandoned) and one instruction slot for decode
    bit          m_starting;
    bit          m_req;
    bit          m_live;
    bit          m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;

    always @(posedge clk or negedge rst_n) begin : model
        bit          req, live, valid;
        logic [31:0] addr, pc, winst, ipc, tgt;
        if (!rst_n) begin
            m_starting <= 1'b1;
            m_req      <= 1'b0;
            m_live     <= 1'b0;
            m_valid    <= 1'b0;
            m_addr     <= 32'h0;
            m_pc       <= 32'h0;
            m_inst     <= 32'h0000_0013;
            m_ipc      <= 32'h0;
        end else begin
            req = m_req; live = m_live; valid = m_valid;
            addr = m_addr; pc = m_pc; winst = m_inst; ipc = m_ipc;
            tgt = {redirect_pc[31:2], 2'b00};
            if (m_starting) begin
                req = 1'b1; live = 1'b1; addr = pc;
            end else if (req) begin
                if (imem_ack) begin
                    if (live && !redirect_valid) begin
                        valid = 1'b1; winst = imem_rdata; ipc = addr; pc = addr + 32'd4; req = 1'b0;
                    end else begin
                        if (redirect_valid) pc = tgt;
                        addr = pc; live = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc = tgt; live = 1'b0;
                end
            end else if (redirect_valid || inst_ready) begin
                if (redirect_valid) pc = tgt;
                valid = 1'b0; req = 1'b1; live = 1'b1; addr = pc;
            end
            m_starting <= 1'b0;
            m_req      <= req;
            m_live     <= live;
            m_valid    <= valid;
            m_addr     <= addr;
            m_pc       <= pc;
            m_inst     <= winst;
            m_ipc      <= ipc;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("req", imem_req, m_req);
            if (m_req) check("addr", imem_addr, m_addr);
            check("valid", inst_valid, m_valid);
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_ipc);
            check("opcode", opcode, {25'd0, m_inst[6:0]});
        end
    end

    initial begin
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        inst_ready = 1'b0;

        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_opcode", opcode, 7'b0010011);
        check("rst_inst_pc", inst_pc, 0);
        rst_n = 1'b1;

        // First fetch after reset, acked immediately
        @(negedge clk);
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t1_valid", inst_valid, 1);
        check("t1_inst", inst, 32'h0050_0093);
        check("t1_opcode", opcode, 7'b0010011);
        check("t1_inst_pc", inst_pc, 32'h0);

        // Decode stalls: instruction held, no request
        repeat (4) begin
            @(negedge clk);
            check("t3_req", imem_req, 0);
            check("t3_inst", inst, 32'h0050_0093);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("t3_next_addr", imem_addr, 32'h4);

        // Redirect while waiting: drain old request, then fetch aligned target
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t4_drain_req", imem_req, 1);
        check("t4_drain_addr", imem_addr, 32'h4);
        repeat (2) begin
            @(negedge clk);
            check("t4_hold_addr", imem_addr, 32'h4);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t4_dropped", inst_valid, 0);
        check("t4_new_addr", imem_addr, 32'h0000_0100);
        imem_rdata = 32'h0000_0113;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t4_inst_pc", inst_pc, 32'h0000_0100);

        // Redirect in HOLD with ready: held instruction dropped
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; inst_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0; inst_ready = 1'b0;
        check("t5_valid", inst_valid, 0);
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);

        // Top-of-memory fetch wraps to 0
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("t6_opcode", opcode, 7'h78);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("t6_wrap_addr", imem_addr, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t6_drain_addr", imem_addr, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", imem_req, 0);
        check("t6_async_valid", inst_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            imem_ack       = m_req && ($urandom_range(0, 2) == 0);
            imem_rdata     = $urandom;
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom);
            inst_ready     = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        imem_ack = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
